div_unit: RTL and testbench

//  Multi-cycle 32-bit integer divider for DIV/DIVU in the 54-instruction MIPS CPU.

---
 rtl/div_unit_pkg.sv | 12 +
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 177 +++++++++++++++++
 tb/tb_div_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: width and FSM state encodings.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor,
// keep the difference and set the quotient bit when there is no borrow.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; diff[WIDTH] is the borrow while rem < divisor holds.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: restoring division on magnitudes, one bit per clock,
// followed by a sign fix-up cycle. Quotient feeds LO, remainder feeds HI.
// Optional feature macro: DIV_EARLY_ZERO_EN (zero divisor skips the iterations and
// exposes the dz flag).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_EARLY_ZERO_EN
    ,
    output logic             dz
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] rem_acc, rem_acc_d;
    logic [WIDTH-1:0] quo_acc, quo_acc_d;
    logic [WIDTH-1:0] div_mag, div_mag_d;
    logic [WIDTH-1:0] dvd_raw, dvd_raw_d;
    logic             sign_q, sign_q_d;
    logic             sign_r, sign_r_d;
    logic             zero, zero_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;
`ifdef DIV_EARLY_ZERO_EN
    logic             dz_d;
`endif

    // Operand magnitudes; negative only matters in signed mode.
    always_comb begin
        a_neg = is_signed & dividend[WIDTH-1];
        b_neg = is_signed & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        b_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_acc),
        .quo      (quo_acc),
        .divisor  (div_mag),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Next-state and next-value logic for the FSM and datapath.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rem_acc_d   = rem_acc;
        quo_acc_d   = quo_acc;
        div_mag_d   = div_mag;
        dvd_raw_d   = dvd_raw;
        sign_q_d    = sign_q;
        sign_r_d    = sign_r;
        zero_d      = zero;
        busy_d      = busy;
        done_d      = 1'b0;
        quotient_d  = quotient;
        remainder_d = remainder;
`ifdef DIV_EARLY_ZERO_EN
        dz_d        = dz;
`endif
        case (state)
            DIV_ST_IDLE: begin
                if (start) begin
                    rem_acc_d = '0;
                    quo_acc_d = a_mag;
                    div_mag_d = b_mag;
                    dvd_raw_d = dividend;
                    sign_q_d  = a_neg ^ b_neg;
                    sign_r_d  = a_neg;
                    zero_d    = (divisor == '0);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = DIV_ST_CALC;
`ifdef DIV_EARLY_ZERO_EN
                    dz_d      = 1'b0;
                    if (divisor == '0) begin
                        state_d = DIV_ST_FIX;
                    end
`endif
                end
            end
            DIV_ST_CALC: begin
                rem_acc_d = step_rem;
                quo_acc_d = step_quo;
                cnt_d     = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_ST_FIX;
                end
            end
            DIV_ST_FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DIV_ST_IDLE;
                if (zero) begin
                    quotient_d  = '1;
                    remainder_d = dvd_raw;
                end else begin
                    quotient_d  = sign_q ? (~quo_acc + WIDTH'(1)) : quo_acc;
                    remainder_d = sign_r ? (~rem_acc + WIDTH'(1)) : rem_acc;
                end
`ifdef DIV_EARLY_ZERO_EN
                dz_d = zero;
`endif
            end
            default: begin
                state_d = DIV_ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DIV_ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            div_mag   <= '0;
            dvd_raw   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_EARLY_ZERO_EN
            dz        <= 1'b0;
`endif
        end else begin
            cnt       <= cnt_d;
            rem_acc   <= rem_acc_d;
            quo_acc   <= quo_acc_d;
            div_mag   <= div_mag_d;
            dvd_raw   <= dvd_raw_d;
            sign_q    <= sign_q_d;
            sign_r    <= sign_r_d;
            zero      <= zero_d;
            busy      <= busy_d;
            done      <= done_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
`ifdef DIV_EARLY_ZERO_EN
            dz        <= dz_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model compared every cycle,
// directed literal cases, then randomized traffic with occasional resets.
// Honours DIV_EARLY_ZERO_EN the same way as the design.
module tb_div_unit;

    localparam int unsigned W = 32;
`ifdef DIV_EARLY_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef DIV_EARLY_ZERO_EN
    logic         dz;
`endif

    int tests = 0;
    int fails = 0;

    div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_EARLY_ZERO_EN
        ,
        .dz        (dz)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference result from plain integer arithmetic (64-bit to avoid overflow traps).
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endtask

    // Behavioural model: transaction-level timing (accept, fixed latency, done pulse).
    logic         m_busy, m_done, m_dz, p_zero, was_busy;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    int           m_left;

    // Model update at each edge, then compare DUT outputs shortly after the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_q = '0; m_r = '0; m_left = 0;
        end else begin
            was_busy = m_busy;
            m_done   = 1'b0;
            if (was_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_zero;
                end
            end
            if (!was_busy && start) begin
                ref_div(dividend, divisor, is_signed, p_q, p_r);
                p_zero = (divisor == '0);
                m_left = p_zero ? ZLAT : 33;
                m_busy = 1'b1;
                m_dz   = 1'b0;
            end
        end
        #1;
        check("busy", W'(busy), W'(m_busy));
        check("done", W'(done), W'(m_done));
        check("quotient", quotient, m_q);
        check("remainder", remainder, m_r);
`ifdef DIV_EARLY_ZERO_EN
        check("dz", W'(dz), W'(m_dz));
`endif
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'(($urandom));
    endtask

    // Waits (bounded) for the done pulse; cyc counts edges after the call point.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while (!done && cyc < 100);
        check("done_seen", W'(done), W'(1));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    int           cyc, ndone;
    logic [W-1:0] tq, tr;

    initial begin
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_q", quotient, '0);
        check("rst_r", remainder, '0);

        // Pin the reference model with hand-computed values.
        ref_div(32'd100, 32'd7, 1'b0, tq, tr);
        check("model_divu_q", tq, 32'd14);
        check("model_divu_r", tr, 32'd2);
        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, tq, tr);
        check("model_div_q", tq, 32'hFFFF_FFFD);
        check("model_div_r", tr, 32'hFFFF_FFFF);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, tq, tr);
        check("model_ovf_q", tq, 32'h8000_0000);
        check("model_ovf_r", tr, 32'h0);

        // DIVU 100/7 with literal latency.
        issue(32'd100, 32'd7, 1'b0);
        check("t1_busy", W'(busy), W'(1));
        wait_done(cyc);
        check("t1_lat", W'(cyc), W'(33));
        check("t1_q", quotient, 32'd14);
        check("t1_r", remainder, 32'd2);

        // Back-to-back: start issued in the done cycle.
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        check("t6_held_q", quotient, 32'd14);
        wait_done(cyc);
        check("t6_lat", W'(cyc), W'(33));
        check("t2_q", quotient, 32'hFFFF_FFFD);
        check("t2_r", remainder, 32'hFFFF_FFFF);

        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(cyc);
        check("t3_ovf_q", quotient, 32'h8000_0000);
        check("t3_ovf_r", remainder, 32'h0);

        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done(cyc);
        check("t3_u_q", quotient, 32'hFFFF_FFFF);
        check("t3_u_r", remainder, 32'h0);

        // Divide by zero, unsigned and signed.
        issue(32'd5, 32'd0, 1'b0);
        wait_done(cyc);
        check("t4_lat", W'(cyc), W'(ZLAT));
        check("t4_q", quotient, 32'hFFFF_FFFF);
        check("t4_r", remainder, 32'd5);
`ifdef DIV_EARLY_ZERO_EN
        check("t4_dz", W'(dz), W'(1));
`endif
        issue(32'hFFFF_FFF7, 32'd0, 1'b1);
        wait_done(cyc);
        check("t4s_q", quotient, 32'hFFFF_FFFF);
        check("t4s_r", remainder, 32'hFFFF_FFF7);

        // Start pulsed at E5 while busy is ignored.
        issue(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd99; divisor = 32'd1; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("t5_busy_lat", W'(cyc), W'(28));
        check("t5_busy_q", quotient, 32'd14);
        check("t5_busy_r", remainder, 32'd2);

        // Reset at E10 aborts the operation.
        repeat (2) @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_busy", W'(busy), W'(0));
        check("t5_rst_done", W'(done), W'(0));
        check("t5_rst_q", quotient, '0);
        check("t5_rst_r", remainder, '0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t5_no_done", W'(ndone), W'(0));

        // Randomized traffic with rare resets.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            is_signed = 1'($urandom_range(0, 1));
            dividend  = pick();
            divisor   = pick();
            rst_n     = ($urandom_range(0, 799) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
